// File: rtl/rv_bus_arbiter.sv
// rv_bus_arbiter: shares one memory bus between fetch and data ports, one outstanding cycle with timeout.
// Define RV_BUS_ARB_RR_EN for round-robin tie-breaking; otherwise data has fixed priority.
module rv_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_instr_req,
  input  logic [31:0] i_instr_addr,
  output logic        o_instr_ack,
  output logic        o_instr_err,
  output logic [31:0] o_instr_data,
  input  logic        i_data_req,
  input  logic [31:0] i_data_addr,
  input  logic [3:0]  i_data_sel,
  input  logic [31:0] i_data_wdata,
  input  logic        i_data_write,
  output logic        o_data_ack,
  output logic        o_data_err,
  output logic [31:0] o_data_rdata,
  output logic        o_bus_req,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_sel,
  output logic [31:0] o_bus_data,
  output logic        o_bus_write,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_data,
  output logic        o_bus_owner
);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT_CYCLES);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             bus_req_q, bus_req_d, bus_write_q, bus_write_d, bus_owner_q, bus_owner_d;
  logic [31:0]      bus_addr_q, bus_addr_d, bus_data_q, bus_data_d;
  logic [3:0]       bus_sel_q, bus_sel_d;
  logic             instr_ack_q, instr_ack_d, instr_err_q, instr_err_d;
  logic             data_ack_q, data_ack_d, data_err_q, data_err_d;
  logic [31:0]      instr_data_q, instr_data_d, data_rdata_q, data_rdata_d;
  logic             grant_data, tmo, done;
  logic [31:0]      rd_v;
`ifdef RV_BUS_ARB_RR_EN
  logic             last_owner_q, last_owner_d;
  assign grant_data = i_data_req & (~i_instr_req | ~last_owner_q);
`else
  assign grant_data = i_data_req;
`endif
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign tmo     = (TIMEOUT_CYCLES != 0) && (cnt_inc == TO);
  assign done    = i_bus_ack | tmo;
  // stores and timeouts return zero data
  assign rd_v    = (bus_write_q | ~i_bus_ack) ? 32'h0 : i_bus_data;
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bus_req_d    = bus_req_q;
    bus_addr_d   = bus_addr_q;
    bus_sel_d    = bus_sel_q;
    bus_data_d   = bus_data_q;
    bus_write_d  = bus_write_q;
    bus_owner_d  = bus_owner_q;
    instr_ack_d  = 1'b0;
    instr_err_d  = 1'b0;
    instr_data_d = 32'h0;
    data_ack_d   = 1'b0;
    data_err_d   = 1'b0;
    data_rdata_d = 32'h0;
`ifdef RV_BUS_ARB_RR_EN
    last_owner_d = last_owner_q;
`endif
    unique case (state_q)
      IDLE: if (i_instr_req | i_data_req) begin
        state_d     = BUS;
        cnt_d       = '0;
        bus_req_d   = 1'b1;
        bus_owner_d = grant_data;
        bus_addr_d  = grant_data ? i_data_addr : i_instr_addr;
        bus_sel_d   = grant_data ? i_data_sel : 4'hF;
        bus_write_d = grant_data & i_data_write;
        bus_data_d  = (grant_data & i_data_write) ? i_data_wdata : 32'h0;
`ifdef RV_BUS_ARB_RR_EN
        last_owner_d = grant_data;
`endif
      end
      BUS: begin
        cnt_d = cnt_inc;
        if (done) begin
          state_d      = RESP;
          bus_req_d    = 1'b0;
          bus_addr_d   = 32'h0;
          bus_sel_d    = 4'h0;
          bus_data_d   = 32'h0;
          bus_write_d  = 1'b0;
          bus_owner_d  = 1'b0;
          instr_ack_d  = ~bus_owner_q;
          instr_err_d  = ~bus_owner_q & ~i_bus_ack;
          instr_data_d = bus_owner_q ? 32'h0 : rd_v;
          data_ack_d   = bus_owner_q;
          data_err_d   = bus_owner_q & ~i_bus_ack;
          data_rdata_d = bus_owner_q ? rd_v : 32'h0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bus_req_q    <= 1'b0;
      bus_addr_q   <= 32'h0;
      bus_sel_q    <= 4'h0;
      bus_data_q   <= 32'h0;
      bus_write_q  <= 1'b0;
      bus_owner_q  <= 1'b0;
      instr_ack_q  <= 1'b0;
      instr_err_q  <= 1'b0;
      instr_data_q <= 32'h0;
      data_ack_q   <= 1'b0;
      data_err_q   <= 1'b0;
      data_rdata_q <= 32'h0;
`ifdef RV_BUS_ARB_RR_EN
      last_owner_q <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bus_req_q    <= bus_req_d;
      bus_addr_q   <= bus_addr_d;
      bus_sel_q    <= bus_sel_d;
      bus_data_q   <= bus_data_d;
      bus_write_q  <= bus_write_d;
      bus_owner_q  <= bus_owner_d;
      instr_ack_q  <= instr_ack_d;
      instr_err_q  <= instr_err_d;
      instr_data_q <= instr_data_d;
      data_ack_q   <= data_ack_d;
      data_err_q   <= data_err_d;
      data_rdata_q <= data_rdata_d;
`ifdef RV_BUS_ARB_RR_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end
  assign o_bus_req    = bus_req_q;
  assign o_bus_addr   = bus_addr_q;
  assign o_bus_sel    = bus_sel_q;
  assign o_bus_data   = bus_data_q;
  assign o_bus_write  = bus_write_q;
  assign o_bus_owner  = bus_owner_q;
  assign o_instr_ack  = instr_ack_q;
  assign o_instr_err  = instr_err_q;
  assign o_instr_data = instr_data_q;
  assign o_data_ack   = data_ack_q;
  assign o_data_err   = data_err_q;
  assign o_data_rdata = data_rdata_q;
endmodule

// File: tb/tb_rv_bus_arbiter.sv
// tb_rv_bus_arbiter: directed checks of grant, timing, timeout, tie-break and async reset.
module tb_rv_bus_arbiter;
  logic        i_clk = 1'b0, i_reset_n = 1'b0;
  logic        i_instr_req = 1'b0, i_data_req = 1'b0, i_data_write = 1'b0, i_bus_ack = 1'b0;
  logic [31:0] i_instr_addr = '0, i_data_addr = '0, i_data_wdata = '0, i_bus_data = '0;
  logic [3:0]  i_data_sel = '0;
  logic        o_instr_ack, o_instr_err, o_data_ack, o_data_err;
  logic        o_bus_req, o_bus_write, o_bus_owner;
  logic [31:0] o_instr_data, o_data_rdata, o_bus_addr, o_bus_data;
  logic [3:0]  o_bus_sel;
  int          n_cmp = 0, n_bad = 0;
  rv_bus_arbiter #(.TIMEOUT_CYCLES(8), .CNT_W(8)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_instr_req(i_instr_req), .i_instr_addr(i_instr_addr),
    .o_instr_ack(o_instr_ack), .o_instr_err(o_instr_err), .o_instr_data(o_instr_data),
    .i_data_req(i_data_req), .i_data_addr(i_data_addr), .i_data_sel(i_data_sel),
    .i_data_wdata(i_data_wdata), .i_data_write(i_data_write),
    .o_data_ack(o_data_ack), .o_data_err(o_data_err), .o_data_rdata(o_data_rdata),
    .o_bus_req(o_bus_req), .o_bus_addr(o_bus_addr), .o_bus_sel(o_bus_sel),
    .o_bus_data(o_bus_data), .o_bus_write(o_bus_write),
    .i_bus_ack(i_bus_ack), .i_bus_data(i_bus_data), .o_bus_owner(o_bus_owner)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask
  function automatic logic [31:0] flags;
    return {25'h0, o_bus_req, o_bus_write, o_bus_owner, o_instr_ack, o_instr_err, o_data_ack, o_data_err};
  endfunction
  task automatic all_zero(input string tag);
    chk({tag, "_flags"}, flags(), 32'h0);
    chk({tag, "_addr"}, o_bus_addr | o_bus_data | {28'h0, o_bus_sel}, 32'h0);
    chk({tag, "_rdata"}, o_instr_data | o_data_rdata, 32'h0);
  endtask
  // expects a grant to exp_owner this cycle, acks it, and returns two cycles after the ack pulse
  task automatic grant_ack(input string tag, input logic exp_owner, input logic [31:0] rd);
    chk({tag, "_req"}, {31'h0, o_bus_req}, 32'h1);
    chk({tag, "_owner"}, {31'h0, o_bus_owner}, {31'h0, exp_owner});
    i_bus_ack = 1'b1;
    i_bus_data = rd;
    tick;
    i_bus_ack = 1'b0;
    chk({tag, "_acks"}, {30'h0, o_instr_ack, o_data_ack}, exp_owner ? 32'h1 : 32'h2);
    chk({tag, "_data"}, exp_owner ? o_data_rdata : o_instr_data, rd);
    if (exp_owner) i_data_req = 1'b0;
    else i_instr_req = 1'b0;
    tick;
    tick;
  endtask
  initial begin
    int n;
    logic first;
    repeat (2) tick;
    all_zero("reset");
    i_reset_n = 1'b1;
    tick;
    // fetch only, slave acks in first BUS cycle
    i_instr_req = 1'b1;
    i_instr_addr = 32'h100;
    tick;
    chk("f_req", {31'h0, o_bus_req}, 32'h1);
    chk("f_addr", o_bus_addr, 32'h100);
    chk("f_sel_wr", {27'h0, o_bus_sel, o_bus_write}, {27'h0, 4'hF, 1'b0});
    chk("f_early_ack", {31'h0, o_instr_ack}, 32'h0);
    i_bus_ack = 1'b1;
    i_bus_data = 32'h13;
    tick;
    i_bus_ack = 1'b0;
    i_instr_req = 1'b0;
    chk("f_ack", {29'h0, o_instr_ack, o_instr_err, o_bus_req}, 32'h4);
    chk("f_data", o_instr_data, 32'h13);
    chk("f_data_port", {31'h0, o_data_ack}, 32'h0);
    tick;
    chk("f_pulse", {31'h0, o_instr_ack}, 32'h0);
    tick;
    // store with four wait states; requester inputs wiggle while owned
    i_data_req = 1'b1;
    i_data_addr = 32'h2004;
    i_data_sel = 4'b1100;
    i_data_wdata = 32'hDEAD0000;
    i_data_write = 1'b1;
    tick;
    chk("s_addr", o_bus_addr, 32'h2004);
    chk("s_bus", {27'h0, o_bus_sel, o_bus_owner}, {27'h0, 4'b1100, 1'b1});
    chk("s_wdata", o_bus_data, 32'hDEAD0000);
    n = 0;
    i_bus_data = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      if (o_bus_write) n++;
      if (i == 1) i_data_addr = 32'h9999;
      if (i == 3) chk("s_hold_addr", o_bus_addr, 32'h2004);
      i_bus_ack = (i == 4);
      tick;
    end
    i_bus_ack = 1'b0;
    chk("s_write_cycles", n, 5);
    chk("s_ack", {29'h0, o_data_ack, o_data_err, o_instr_ack}, 32'h4);
    chk("s_rdata", o_data_rdata, 32'h0);
    i_data_req = 1'b0;
    i_data_write = 1'b0;
    tick;
    tick;
    // two tie rounds
    for (int r = 0; r < 2; r++) begin
      i_instr_req = 1'b1;
      i_data_req = 1'b1;
      i_instr_addr = 32'h300 + r;
      i_data_addr = 32'h400 + r;
      tick;
`ifdef RV_BUS_ARB_RR_EN
      first = 1'b0;
`else
      first = 1'b1;
`endif
      chk("t_addr", o_bus_addr, first ? 32'h400 + r : 32'h300 + r);
      grant_ack("t_first", first, 32'hA0 + r);
      grant_ack("t_second", ~first, 32'hB0 + r);
    end
    // timeout with slave never acking; spurious acks in RESP and IDLE
    i_data_req = 1'b1;
    i_data_addr = 32'h500;
    i_bus_data = 32'h12345678;
    tick;
    n = 0;
    while (o_bus_req && n < 20) begin
      n++;
      tick;
    end
    chk("to_req_cycles", n, 8);
    chk("to_ack_err", {29'h0, o_data_ack, o_data_err, o_instr_ack}, 32'h6);
    chk("to_rdata", o_data_rdata, 32'h0);
    i_data_req = 1'b0;
    i_bus_ack = 1'b1;
    tick;
    chk("sp_resp", flags(), 32'h0);
    repeat (3) tick;
    chk("sp_idle", flags(), 32'h0);
    i_bus_ack = 1'b0;
    tick;
    chk("sp_after", flags(), 32'h0);
    // asynchronous reset while a fetch owns the bus
    i_instr_req = 1'b1;
    i_instr_addr = 32'h600;
    tick;
    chk("r_busy", {31'h0, o_bus_req}, 32'h1);
    #1 i_reset_n = 1'b0;
    #1 all_zero("r_async");
    i_instr_req = 1'b0;
    tick;
    i_reset_n = 1'b1;
    tick;
    i_instr_req = 1'b1;
    i_instr_addr = 32'h200;
    tick;
    chk("r_addr", o_bus_addr, 32'h200);
    grant_ack("r_fetch", 1'b0, 32'h55);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
